// File: rtl/mac_pkg.sv
// mac_pkg: shared accumulator types and the shift-then-clamp helper used by the MAC result path.
package mac_pkg;
  localparam int ACC_W = 16;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [7:0] prod_t;
  function automatic acc_t sat_shift(input acc_t d, input int shift, input int out_w);
    int v, hi;
    v = int'(d >>> shift);
    hi = (1 << (out_w - 1)) - 1;
    return v > hi ? acc_t'(hi) : v < -hi - 1 ? acc_t'(-hi - 1) : acc_t'(v);
  endfunction
endpackage

// File: rtl/mac_result_fifo.sv
// mac_result_fifo: DEPTH x 16 synchronous FIFO with a registered head that holds its last value when empty.
module mac_result_fifo import mac_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  acc_t                     din,
  output acc_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  acc_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign level = cnt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // dout tracks the entry that becomes the head after this edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      dout <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (pop && cnt > (AW+1)'(1)) dout <= mem[rd_ptr + 1'b1];
      else if (push && (empty || pop)) dout <= din;
    end
  end
endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: groups VEC_LEN MAC products into dot-product deltas and queues them on a ready/valid port.
// Define MAC_COLLECT_SAT_EN to compile in the SHIFT/OUT_W shift-and-saturate stage.
module mac_result_collector import mac_pkg::*; #(
  parameter int VEC_LEN = 4,
  parameter int DEPTH   = 4,
  parameter int SHIFT   = 0,
  parameter int OUT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  acc_t                   f_in,
  input  logic                   mac_valid,
  input  logic                   sync_clr,
  output acc_t                   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  if (VEC_LEN < 1 || VEC_LEN > 255 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      SHIFT < 0 || SHIFT > 15 || OUT_W < 2 || OUT_W > 16) begin : g_bad_cfg
    $error("mac_result_collector: parameter out of range");
  end
  logic [7:0] cnt;
  acc_t base, delta, proc;
  logic at_end, boundary, full, empty, pop, push;
  assign at_end = cnt == 8'(VEC_LEN - 1);
  assign boundary = mac_valid && !sync_clr && at_end;
  // modular difference makes accumulator wrap-around transparent
  assign delta = f_in - base;
`ifdef MAC_COLLECT_SAT_EN
  assign proc = sat_shift(delta, SHIFT, OUT_W);
`else
  assign proc = delta;
`endif
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign push = boundary && (!full || pop);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      base <= '0;
      overflow <= 1'b0;
    end else begin
      if (sync_clr || boundary) base <= f_in;
      if (sync_clr || boundary) cnt <= '0;
      else if (mac_valid) cnt <= cnt + 8'd1;
      if (boundary && full && !pop) overflow <= 1'b1;
    end
  end
  mac_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din(proc),
    .dout(out_data),
    .full(full),
    .empty(empty),
    .level(level)
  );
endmodule
